// File: rtl/i2c_codec_slave_if.sv
// I2C pad-side bus bundle for the codec control port.
// The master modport drives SCL and the resolved SDA level; the slave drives the open-drain enable.
interface i2c_codec_slave_if;
    logic I2C_SCLK;
    logic I2C_SDAT_IN;
    logic I2C_SDAT_OE;

    modport master (output I2C_SCLK, output I2C_SDAT_IN, input  I2C_SDAT_OE);
    modport slave  (input  I2C_SCLK, input  I2C_SDAT_IN, output I2C_SDAT_OE);
endinterface

// File: rtl/i2c_codec_slave.sv
// I2C write-only target emulating the audio codec control port.
// Takes 3-byte writes, stores them in a 10-entry 9-bit register file and reports protocol errors.
module i2c_codec_slave #(
    parameter logic [6:0] DEV_ADDR    = 7'h1A,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                iRST_N,
    i2c_codec_slave_if.slave    bus,
    output logic                wr_strobe,
    output logic [6:0]          wr_addr,
    output logic [8:0]          wr_data,
    input  logic [3:0]          rd_addr,
    output logic [8:0]          rd_data,
    output logic                codec_active,
    output logic                xfer_err
);

    localparam int SYNC_N   = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int NUM_REGS = 10;

    typedef enum logic [3:0] {
        ST_IDLE, ST_ADDR, ST_ACK_A, ST_BYTE1, ST_ACK1,
        ST_BYTE2, ST_ACK2, ST_EXTRA, ST_WAIT_STOP
    } state_t;

    function automatic logic [8:0] reg_default(input logic [3:0] idx);
        case (idx)
            4'd0, 4'd1: reg_default = 9'h097;
            4'd2, 4'd3: reg_default = 9'h079;
            4'd4:       reg_default = 9'h00A;
            4'd5:       reg_default = 9'h008;
            4'd6:       reg_default = 9'h09F;
            4'd7:       reg_default = 9'h00A;
            default:    reg_default = 9'h000;
        endcase
    endfunction

    logic [SYNC_N-1:0] r_scl_sync, r_sda_sync;
    logic              r_scl_d, r_sda_d;
    logic              w_scl, w_sda;
    logic              w_scl_rise, w_scl_fall, w_start, w_stop;

    // Sync flops idle high so reset release never fakes a START or STOP.
    always_ff @(posedge clk or negedge iRST_N) begin
        if (!iRST_N) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_N-2:0], bus.I2C_SCLK};
            r_sda_sync <= {r_sda_sync[SYNC_N-2:0], bus.I2C_SDAT_IN};
            r_scl_d    <= w_scl;
            r_sda_d    <= w_sda;
        end
    end

    assign w_scl      = r_scl_sync[SYNC_N-1];
    assign w_sda      = r_sda_sync[SYNC_N-1];
    assign w_scl_rise =  w_scl & ~r_scl_d;
    assign w_scl_fall = ~w_scl &  r_scl_d;
    assign w_start    =  w_scl & r_scl_d &  r_sda_d & ~w_sda;
    assign w_stop     =  w_scl & r_scl_d & ~r_sda_d &  w_sda;

    state_t      r_state;
    logic [2:0]  r_cnt;
    logic [6:0]  r_shift;
    logic [7:0]  r_byte1;
    logic        r_oe;
    logic        r_wr_strobe;
    logic [6:0]  r_wr_addr;
    logic [8:0]  r_wr_data;
    logic        r_xfer_err;
    logic [8:0]  r_regs [NUM_REGS];
    logic [7:0]  w_byte;
    logic [6:0]  w_new_addr;
    logic [8:0]  w_new_data;

    assign w_byte     = {r_shift, w_sda};
    assign w_new_addr = r_byte1[7:1];
    assign w_new_data = {r_byte1[0], w_byte};

    // NOTE: the register file is reset explicitly because the defaults are architectural state,
    // not power-up noise; an R15 write reloads the same values.
    always_ff @(posedge clk or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_byte1     <= '0;
            r_oe        <= 1'b0;
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_xfer_err  <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= reg_default(i[3:0]);
        end else begin
            r_wr_strobe <= 1'b0;
            r_xfer_err  <= 1'b0;
            if (w_start) begin
                r_state <= ST_ADDR;
                r_cnt   <= '0;
                r_oe    <= 1'b0;
            end else if (w_stop) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_oe    <= 1'b0;
            end else begin
                case (r_state)
                    ST_ADDR, ST_BYTE1, ST_BYTE2, ST_EXTRA: begin
                        if (w_scl_rise) begin
                            r_shift <= w_byte[6:0];
                            r_cnt   <= r_cnt + 3'd1;
                            if (r_cnt == 3'd7) begin
                                if (r_state == ST_ADDR) begin
                                    if (w_byte == {DEV_ADDR, 1'b0}) begin
                                        r_state <= ST_ACK_A;
                                    end else begin
                                        r_xfer_err <= 1'b1;
                                        r_state    <= ST_WAIT_STOP;
                                    end
                                end else if (r_state == ST_BYTE1) begin
                                    r_byte1 <= w_byte;
                                    r_state <= ST_ACK1;
                                end else if (r_state == ST_BYTE2) begin
                                    r_wr_strobe <= 1'b1;
                                    r_wr_addr   <= w_new_addr;
                                    r_wr_data   <= w_new_data;
                                    if (w_new_addr == 7'd15) begin
                                        for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= reg_default(i[3:0]);
                                    end else if (w_new_addr < 7'(NUM_REGS)) begin
                                        r_regs[w_new_addr[3:0]] <= w_new_data;
                                    end
                                    r_state <= ST_ACK2;
                                end else begin
                                    r_xfer_err <= 1'b1;
                                    r_state    <= ST_WAIT_STOP;
                                end
                            end
                        end
                    end
                    // First SCL fall after the 8th bit drives ACK, the next one releases it.
                    ST_ACK_A, ST_ACK1, ST_ACK2: begin
                        if (w_scl_fall) begin
                            if (!r_oe) begin
                                r_oe <= 1'b1;
                            end else begin
                                r_oe  <= 1'b0;
                                r_cnt <= '0;
                                case (r_state)
                                    ST_ACK_A: r_state <= ST_BYTE1;
                                    ST_ACK1:  r_state <= ST_BYTE2;
                                    default:  r_state <= ST_EXTRA;
                                endcase
                            end
                        end
                    end
                    default: begin
                        r_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

    // NOTE: default assignment first keeps this combinational read free of inferred latches.
    always_comb begin
        rd_data = '0;
        if (rd_addr < 4'(NUM_REGS)) rd_data = r_regs[rd_addr];
    end

    assign bus.I2C_SDAT_OE = r_oe;
    assign wr_strobe       = r_wr_strobe;
    assign wr_addr         = r_wr_addr;
    assign wr_data         = r_wr_data;
    assign xfer_err        = r_xfer_err;
    assign codec_active    = r_regs[9][0];

endmodule
